// File: rtl/uart_cmd_deframer.sv
// Frames 9-byte host commands (opcode + 8 payload bytes) popped from the UART RX FIFO
// and hands validated packets to the command hub over a valid/ready handshake.
module uart_cmd_deframer #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CNT_W          = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_data_present,
    output logic        rx_read,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  cmd_opcode,
    output logic [63:0] cmd_payload,
    output logic        err_bad_opcode,
    output logic        err_timeout,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PAYLOAD = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;

    localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [2:0]       count_q, count_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic             bad_q, bad_d;
    logic [7:0]       opcode_buf_q, opcode_buf_d;
    logic [55:0]      slot_q, slot_d;
    logic             rx_read_q, rx_read_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic [7:0]       cmd_opcode_q, cmd_opcode_d;
    logic [63:0]      cmd_payload_q, cmd_payload_d;
    logic             err_bad_q, err_bad_d;
    logic             err_to_q, err_to_d;
    logic             busy_q, busy_d;
    logic             slot_wr;

    function automatic logic legal_opcode(input logic [7:0] op);
        logic ok;
        case (op)
            8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
            8'h06, 8'h07, 8'h09, 8'h0A, 8'h0B: ok = 1'b1;
            default:                           ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Payload bytes 1..7 are parked here; byte 8 goes straight from rx_data
    // into the output register when the packet completes.
    assign slot_wr = (state_q == ST_PAYLOAD) && rx_read_q;

    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_slot
            assign slot_d[8*gi +: 8] = (slot_wr && (count_q == 3'(gi))) ? rx_data
                                                                        : slot_q[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        tcnt_d        = tcnt_q;
        bad_d         = bad_q;
        opcode_buf_d  = opcode_buf_q;
        cmd_opcode_d  = cmd_opcode_q;
        cmd_payload_d = cmd_payload_q;
        err_bad_d     = 1'b0;
        err_to_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_read_q) begin
                    opcode_buf_d = rx_data;
                    bad_d        = !legal_opcode(rx_data);
                    count_d      = 3'd0;
                    tcnt_d       = CNT_ONE;
                    state_d      = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (rx_read_q) begin
                    tcnt_d  = CNT_ONE;
                    count_d = count_q + 3'd1;
                    if (count_q == 3'd7) begin
                        count_d = 3'd0;
                        if (bad_q) begin
                            err_bad_d = 1'b1;
                            state_d   = ST_IDLE;
                        end else begin
                            cmd_opcode_d  = opcode_buf_q;
                            cmd_payload_d = {rx_data, slot_q};
                            state_d       = ST_HOLD;
                        end
                    end
                end else if (tcnt_q + CNT_ONE == TIMEOUT_LIMIT) begin
                    // tcnt_q counts cycles since the last read, so the pulse
                    // lands exactly TIMEOUT_CYCLES after that read cycle.
                    err_to_d = 1'b1;
                    state_d  = ST_IDLE;
                    count_d  = 3'd0;
                    tcnt_d   = '0;
                end else begin
                    tcnt_d = tcnt_q + CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (cmd_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Looking at the next state lets a read start in the cycle cmd_valid drops.
        rx_read_d   = ((state_d == ST_IDLE) || (state_d == ST_PAYLOAD)) &&
                      rx_data_present && !rx_read_q;
        cmd_valid_d = (state_d == ST_HOLD);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            count_q       <= '0;
            tcnt_q        <= '0;
            bad_q         <= 1'b0;
            opcode_buf_q  <= '0;
            slot_q        <= '0;
            rx_read_q     <= 1'b0;
            cmd_valid_q   <= 1'b0;
            cmd_opcode_q  <= '0;
            cmd_payload_q <= '0;
            err_bad_q     <= 1'b0;
            err_to_q      <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            tcnt_q        <= tcnt_d;
            bad_q         <= bad_d;
            opcode_buf_q  <= opcode_buf_d;
            slot_q        <= slot_d;
            rx_read_q     <= rx_read_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_opcode_q  <= cmd_opcode_d;
            cmd_payload_q <= cmd_payload_d;
            err_bad_q     <= err_bad_d;
            err_to_q      <= err_to_d;
            busy_q        <= busy_d;
        end
    end

    assign rx_read        = rx_read_q;
    assign cmd_valid      = cmd_valid_q;
    assign cmd_opcode     = cmd_opcode_q;
    assign cmd_payload    = cmd_payload_q;
    assign err_bad_opcode = err_bad_q;
    assign err_timeout    = err_to_q;
    assign busy           = busy_q;

endmodule
